// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and defaults for the IF/EXE single-port SRAM arbiter.
package sram_port_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W       = 32;
    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_STARVE_LIMIT = 4;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e owner;
    } resp_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester handshakes plus SRAM macro signals; master = pipeline/macro side, slave = arbiter.
interface sram_port_arbiter_if
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic              data_wr;
    logic [STRB_W-1:0] data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    logic              sram_ready;
    logic              sram_en;
    logic [STRB_W-1:0] sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport master (
        output inst_req, inst_addr,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output sram_ready, sram_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata
    );

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  sram_ready, sram_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata
    );

endinterface

// File: rtl/sram_port_arbiter_arb_starve_counter.sv
// Counts data grants taken while IF waits; forces an IF grant once the limit is reached.
module arb_starve_counter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic inst_req,
    input  logic inst_grant,
    input  logic data_grant,
    output logic force_inst_c
);
    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt;

    // Stalled cycles (no grant) leave the count untouched while IF keeps requesting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!inst_req || inst_grant) begin
            cnt <= '0;
        end else if (data_grant && (cnt != LIMIT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign force_inst_c = inst_req && (cnt == LIMIT);

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM shared between IF and EXE: same-cycle grant, one-cycle response.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic               clk,
    input  logic               reset,
    sram_port_arbiter_if.slave bus
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              grant_c;
    logic              force_inst_c;
    owner_e            winner_c;
    logic              inst_aok_c;
    logic              data_aok_c;
    logic [STRB_W-1:0] wen_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;
    resp_t             resp;

    // Grant mux: data by default, IF when forced or when it is the only requester.
    always_comb begin
        grant_c    = 1'b0;
        winner_c   = OWN_INST;
        inst_aok_c = 1'b0;
        data_aok_c = 1'b0;
        wen_c      = '0;
        addr_c     = bus.inst_addr;
        wdata_c    = '0;
        if (bus.sram_ready && !reset && (bus.inst_req || bus.data_req)) begin
            grant_c = 1'b1;
            if (force_inst_c) begin
                winner_c = OWN_INST;
            end else if (bus.data_req) begin
                winner_c = OWN_DATA;
            end else begin
                winner_c = OWN_INST;
            end
            if (winner_c == OWN_DATA) begin
                data_aok_c = 1'b1;
                addr_c     = bus.data_addr;
                wdata_c    = bus.data_wdata;
                wen_c      = bus.data_wr ? bus.data_wstrb : '0;
            end else begin
                inst_aok_c = 1'b1;
            end
        end
    end

    arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk         (clk),
        .reset       (reset),
        .inst_req    (bus.inst_req),
        .inst_grant  (inst_aok_c),
        .data_grant  (data_aok_c),
        .force_inst_c(force_inst_c)
    );

    // One response in flight; reset drops it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp <= '{vld: 1'b0, owner: OWN_INST};
        end else begin
            resp <= '{vld: grant_c, owner: winner_c};
        end
    end

    assign bus.inst_addr_ok = inst_aok_c;
    assign bus.data_addr_ok = data_aok_c;
    assign bus.sram_en      = grant_c;
    assign bus.sram_wen     = wen_c;
    assign bus.sram_addr    = addr_c;
    assign bus.sram_wdata   = wdata_c;
    assign bus.inst_data_ok = resp.vld && (resp.owner == OWN_INST);
    assign bus.data_data_ok = resp.vld && (resp.owner == OWN_DATA);
    assign bus.inst_rdata   = bus.sram_rdata;
    assign bus.data_rdata   = bus.sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter, plus a STARVE_LIMIT=0 instance fed the same stimulus.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sram_port_arbiter_if bus  ();
    sram_port_arbiter_if bus0 ();

    sram_port_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
    sram_port_arbiter #(.STARVE_LIMIT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    assign bus0.inst_req   = bus.inst_req;
    assign bus0.inst_addr  = bus.inst_addr;
    assign bus0.data_req   = bus.data_req;
    assign bus0.data_wr    = bus.data_wr;
    assign bus0.data_wstrb = bus.data_wstrb;
    assign bus0.data_addr  = bus.data_addr;
    assign bus0.data_wdata = bus.data_wdata;
    assign bus0.sram_ready = bus.sram_ready;
    assign bus0.sram_rdata = bus.sram_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Control vector {inst_aok, data_aok, en, wen[3:0], inst_dok, data_dok} sampled at negedge.
    task automatic expect_ctl(input string tag, input logic iaok, input logic daok,
                              input logic en, input logic [3:0] wen,
                              input logic idok, input logic ddok);
        @(negedge clk);
        chk(tag, 32'({bus.inst_addr_ok, bus.data_addr_ok, bus.sram_en, bus.sram_wen,
                      bus.inst_data_ok, bus.data_data_ok}),
                 32'({iaok, daok, en, wen, idok, ddok}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.inst_req   = 1'b0;
        bus.inst_addr  = '0;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_wstrb = '0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        bus.sram_ready = 1'b1;
    endtask

    initial begin
        logic [5:0] order;
        logic       w;
        idle();
        bus.sram_rdata = '0;
        reset = 1'b1;
        expect_ctl("reset_idle", 0, 0, 0, 4'h0, 0, 0);
        tick();
        reset = 1'b0;

        // 1: single load
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h100;
        expect_ctl("ld_grant", 0, 1, 1, 4'h0, 0, 0);
        chk("ld_addr", bus.sram_addr, 32'h100);
        tick();
        idle();
        bus.sram_rdata = 32'hDEAD_BEEF;
        expect_ctl("ld_resp", 0, 0, 0, 4'h0, 0, 1);
        chk("ld_rdata", bus.data_rdata, 32'hDEAD_BEEF);
        tick();

        // 2: both held six cycles; bit i set means IF wins cycle i
        order = 6'b010000;
        bus.inst_req   = 1'b1;
        bus.inst_addr  = 32'h400;
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_wstrb = 4'hF;
        bus.data_addr  = 32'h500;
        bus.data_wdata = 32'hAAAA_5555;
        for (int i = 0; i < 6; i++) begin
            w = order[i];
            expect_ctl($sformatf("starve_c%0d", i), w, !w, 1, w ? 4'h0 : 4'hF,
                       (i == 5), (i >= 1) && (i != 5));
            chk($sformatf("starve_addr_c%0d", i), bus.sram_addr, w ? 32'h400 : 32'h500);
            chk($sformatf("lim0_prio_c%0d", i), 32'({bus0.inst_addr_ok, bus0.data_addr_ok}), 32'h2);
            tick();
        end
        idle();
        expect_ctl("starve_tail", 0, 0, 0, 4'h0, 0, 1);
        tick();

        // 3: store with partial strobe, then zero-strobe store
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_wstrb = 4'b0011;
        bus.data_addr  = 32'h200;
        bus.data_wdata = 32'h1234_5678;
        expect_ctl("st_grant", 0, 1, 1, 4'b0011, 0, 0);
        chk("st_wdata", bus.sram_wdata, 32'h1234_5678);
        chk("st_addr", bus.sram_addr, 32'h200);
        tick();
        bus.data_wstrb = 4'b0000;
        bus.data_addr  = 32'h204;
        expect_ctl("st0_grant", 0, 1, 1, 4'h0, 0, 1);
        tick();
        idle();
        expect_ctl("st0_resp", 0, 0, 0, 4'h0, 0, 1);
        tick();

        // 4: ready drops mid-contention; counter must hold at 2
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h440;
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h540;
        expect_ctl("rdy_c0", 0, 1, 1, 4'h0, 0, 0); tick();
        expect_ctl("rdy_c1", 0, 1, 1, 4'h0, 0, 1); tick();
        bus.sram_ready = 1'b0;
        expect_ctl("rdy_stall0", 0, 0, 0, 4'h0, 0, 1); tick();
        expect_ctl("rdy_stall1", 0, 0, 0, 4'h0, 0, 0); tick();
        expect_ctl("rdy_stall2", 0, 0, 0, 4'h0, 0, 0); tick();
        bus.sram_ready = 1'b1;
        expect_ctl("rdy_c5", 0, 1, 1, 4'h0, 0, 0); tick();
        expect_ctl("rdy_c6", 0, 1, 1, 4'h0, 0, 1); tick();
        expect_ctl("rdy_c7", 1, 0, 1, 4'h0, 0, 1); tick();
        expect_ctl("rdy_c8", 0, 1, 1, 4'h0, 1, 0); tick();
        idle();
        expect_ctl("rdy_tail", 0, 0, 0, 4'h0, 0, 1); tick();

        // 5: reset right after a grant drops the response
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_wstrb = 4'hF;
        bus.data_addr  = 32'h300;
        expect_ctl("rst_grant", 0, 1, 1, 4'hF, 0, 0);
        tick();
        reset = 1'b1;
        expect_ctl("rst_drop", 0, 0, 0, 4'h0, 0, 0);
        tick();
        bus.inst_req = 1'b1;
        expect_ctl("rst_hold", 0, 0, 0, 4'h0, 0, 0);
        tick();
        reset = 1'b0;
        idle();
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h304;
        expect_ctl("rst_fresh", 0, 1, 1, 4'h0, 0, 0);
        tick();
        idle();
        bus.sram_rdata = 32'hCAFE_F00D;
        expect_ctl("rst_fresh_resp", 0, 0, 0, 4'h0, 0, 1);
        chk("rst_fresh_rdata", bus.data_rdata, 32'hCAFE_F00D);
        tick();

        // 6: alternating single requesters I,D,I,D
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h10;
        expect_ctl("alt_c0", 1, 0, 1, 4'h0, 0, 0);
        chk("alt_addr0", bus.sram_addr, 32'h10);
        tick();
        idle();
        bus.data_req   = 1'b1;
        bus.data_addr  = 32'h20;
        bus.sram_rdata = 32'h1111_0000;
        expect_ctl("alt_c1", 0, 1, 1, 4'h0, 1, 0);
        chk("alt_irdata1", bus.inst_rdata, 32'h1111_0000);
        tick();
        idle();
        bus.inst_req   = 1'b1;
        bus.inst_addr  = 32'h14;
        bus.sram_rdata = 32'h2222_0000;
        expect_ctl("alt_c2", 1, 0, 1, 4'h0, 0, 1);
        chk("alt_drdata2", bus.data_rdata, 32'h2222_0000);
        tick();
        idle();
        bus.data_req   = 1'b1;
        bus.data_addr  = 32'h24;
        bus.sram_rdata = 32'h3333_0000;
        expect_ctl("alt_c3", 0, 1, 1, 4'h0, 1, 0);
        chk("alt_irdata3", bus.inst_rdata, 32'h3333_0000);
        tick();
        idle();
        bus.sram_rdata = 32'h4444_0000;
        expect_ctl("alt_c4", 0, 0, 0, 4'h0, 0, 1);
        chk("alt_drdata4", bus.data_rdata, 32'h4444_0000);
        tick();
        expect_ctl("alt_c5", 0, 0, 0, 4'h0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
